register_bank_sb: RTL and testbench



---
 rtl/register_bank_sb.sv | 164 ++++++++++++++++
 tb/tb_register_bank_sb.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_sb.sv
// -----------------------------------------------------------------------------
// register_bank_sb
//
// Purpose:
//   Parametrised register bank with NUM_REGS registers of DATA_W bits. It has
//   one binary-addressed synchronous write port, two combinational read ports
//   and a per-register busy scoreboard. Issue logic locks a destination
//   register (marks it busy) and a writeback to that register unlocks it.
//
// Build option:
//   REGBANK_BYPASS_EN - when defined, a write presented on the same cycle is
//                       forwarded to any read port addressing that register.
//                       Sequential behaviour is the same in both builds.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   wr_en      in   write strobe
//   wr_addr    in   [ADDR_W]   write register index
//   wr_data    in   [DATA_W]   write data
//   lock_en    in   issue strobe, marks lock_addr busy
//   lock_addr  in   [ADDR_W]   register to mark busy
//   rd_addr_a  in   [ADDR_W]   read index, port A
//   rd_addr_b  in   [ADDR_W]   read index, port B
//   rd_data_a  out  [DATA_W]   read data, port A (combinational)
//   rd_data_b  out  [DATA_W]   read data, port B (combinational)
//   rd_busy_a  out  busy bit of the register addressed on port A
//   rd_busy_b  out  busy bit of the register addressed on port B
//   busy_mask  out  [NUM_REGS] registered busy vector
//   wr_err     out  one-cycle pulse after an out-of-range write
//   lock_err   out  one-cycle pulse after a bad lock (out of range / busy)
// -----------------------------------------------------------------------------
module register_bank_sb #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       NUM_REGS  = 16,
   parameter int unsigned       ADDR_W    = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                lock_en,
   input  logic [ADDR_W-1:0]   lock_addr,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [DATA_W-1:0]   rd_data_a,
   output logic [DATA_W-1:0]   rd_data_b,
   output logic                rd_busy_a,
   output logic                rd_busy_b,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                wr_err,
   output logic                lock_err
);

`ifdef REGBANK_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // Full address space; addresses at or above NUM_REGS decode to zero entries.
   localparam int unsigned     DEPTH      = 1 << ADDR_W;
   localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                wr_err_q;
   logic                wr_err_d;
   logic                lock_err_q;
   logic                lock_err_d;

   logic wr_in_range;
   logic lock_in_range;
   logic wr_ok;
   logic lock_ok;

   assign wr_in_range   = ({1'b0, wr_addr}   < NUM_REGS_L);
   assign lock_in_range = ({1'b0, lock_addr} < NUM_REGS_L);
   assign wr_ok         = wr_en   & wr_in_range;
   assign lock_ok       = lock_en & lock_in_range;

   // Zero-extended views so every address, legal or not, indexes something.
   logic [DATA_W-1:0] rd_tab [DEPTH];
   logic [DEPTH-1:0]  busy_ext;

   assign busy_ext = DEPTH'(busy_q);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_tab
         if (gi < NUM_REGS) begin : g_real
            assign rd_tab[gi] = regs_q[gi];
         end else begin : g_pad
            assign rd_tab[gi] = '0;
         end
      end

      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic wr_hit;
         logic lock_hit;
         assign wr_hit     = wr_ok   && (wr_addr   == ADDR_W'(gi));
         assign lock_hit   = lock_ok && (lock_addr == ADDR_W'(gi));
         assign regs_d[gi] = wr_hit ? wr_data : regs_q[gi];
         // Lock has priority over the writeback clear on a shared edge.
         assign busy_d[gi] = lock_hit | (busy_q[gi] & ~wr_hit);
      end
   endgenerate

   assign wr_err_d   = wr_en & ~wr_in_range;
   // busy_ext is zero for out-of-range addresses, so the range term covers those.
   assign lock_err_d = lock_en & (~lock_in_range | busy_ext[lock_addr]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
         busy_q     <= '0;
         wr_err_q   <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q     <= busy_d;
         wr_err_q   <= wr_err_d;
         lock_err_q <= lock_err_d;
      end
   end

   // Read ports: stored state, optionally overridden by the in-flight write.
   logic [ADDR_W-1:0] rd_addr [2];
   assign rd_addr[0] = rd_addr_a;
   assign rd_addr[1] = rd_addr_b;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] data_sel;
         logic              busy_sel;
         always_comb begin
            data_sel = rd_tab[rd_addr[gi]];
            busy_sel = busy_ext[rd_addr[gi]];
            if (BYPASS && wr_ok && (wr_addr == rd_addr[gi])) begin
               data_sel = wr_data;
               busy_sel = lock_ok && (lock_addr == wr_addr);
            end
         end
      end
   endgenerate

   assign rd_data_a = g_port[0].data_sel;
   assign rd_busy_a = g_port[0].busy_sel;
   assign rd_data_b = g_port[1].data_sel;
   assign rd_busy_b = g_port[1].busy_sel;

   assign busy_mask = busy_q;
   assign wr_err    = wr_err_q;
   assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_register_bank_sb.sv
module tb_register_bank_sb;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        lock_en = 1'b0;
   logic [3:0]  lock_addr = '0;
   logic [3:0]  rd_addr_a = '0;
   logic [3:0]  rd_addr_b = '0;

   logic [31:0] rd_data_a, rd_data_b;
   logic        rd_busy_a, rd_busy_b;
   logic [15:0] busy_mask;
   logic        wr_err, lock_err;

   logic [31:0] d12_rd_data_a, d12_rd_data_b;
   logic        d12_rd_busy_a, d12_rd_busy_b;
   logic [11:0] d12_busy_mask;
   logic        d12_wr_err, d12_lock_err;

   register_bank_sb dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .lock_en(lock_en), .lock_addr(lock_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
      .busy_mask(busy_mask), .wr_err(wr_err), .lock_err(lock_err)
   );

   register_bank_sb #(.NUM_REGS(12)) dut12 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .lock_en(lock_en), .lock_addr(lock_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(d12_rd_data_a), .rd_data_b(d12_rd_data_b), .rd_busy_a(d12_rd_busy_a),
      .rd_busy_b(d12_rd_busy_b), .busy_mask(d12_busy_mask), .wr_err(d12_wr_err),
      .lock_err(d12_lock_err)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

`ifdef REGBANK_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   passed = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input logic [31:0] val);
      exp_t x;
      x.name = name;
      x.val  = val;
      exp_q.push_back(x);
   endtask

   task automatic idle_inputs();
      wr_en   = 1'b0;
      lock_en = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      $display("[tb] reset asserted with clock stopped");
      push("rst_busy_mask", 32'h0);
      push("rst_wr_err", 32'h0);
      push("rst_lock_err", 32'h0);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, wr_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, wr_err, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, lock_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, lock_err, e.val); else passed++;
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         #1;
         push($sformatf("rst_r%0d", i), 32'h0);
         e = exp_q.pop_front(); checks++;
         if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      end
      // Writes and locks held during reset with the clock running are dropped.
      clk_en = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFF_FFFF;
      lock_en = 1'b1; lock_addr = 4'd5;
      tick(); tick();
      idle_inputs();
      rd_addr_a = 4'd5;
      #1;
      $display("[tb] write+lock r5 during reset");
      push("rst_drop_data", 32'h0);
      push("rst_drop_busy", 32'h0);
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_write_readback();
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF;
      tick();
      $display("[tb] write r5 = deadbeef");
      wr_addr = 4'd15; wr_data = 32'h1234_5678;
      tick();
      $display("[tb] write r15 = 12345678");
      idle_inputs();
      rd_addr_a = 4'd5; rd_addr_b = 4'd15;
      #1;
      push("wb_r5", 32'hDEAD_BEEF);
      push("wb_r15", 32'h1234_5678);
      push("wb_wr_err", 32'h0);
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if (rd_data_b !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_b, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, wr_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, wr_err, e.val); else passed++;
   endtask

   task automatic test_scoreboard();
      lock_en = 1'b1; lock_addr = 4'd3;
      tick();
      $display("[tb] lock r3");
      rd_addr_a = 4'd3;
      #1;
      push("sb_lock_mask", 32'h0008);
      push("sb_lock_rdbusy", 32'h1);
      push("sb_lock_noerr", 32'h0);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, rd_busy_a} !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_busy_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, lock_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, lock_err, e.val); else passed++;

      tick();   // lock_en still asserted: re-lock of busy r3
      $display("[tb] re-lock r3");
      idle_inputs();
      push("sb_relock_err", 32'h1);
      push("sb_relock_mask", 32'h0008);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, lock_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, lock_err, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;
      tick();
      push("sb_relock_pulse_end", 32'h0);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, lock_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, lock_err, e.val); else passed++;

      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5_A5A5;
      tick();
      $display("[tb] write r3 = a5a5a5a5");
      idle_inputs();
      push("sb_unlock_mask", 32'h0000);
      push("sb_unlock_data", 32'hA5A5_A5A5);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
   endtask

   task automatic test_simultaneous();
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h11;
      lock_en = 1'b1; lock_addr = 4'd7;
      tick();
      $display("[tb] lock r7 + write r7 = 11");
      idle_inputs();
      rd_addr_a = 4'd7;
      #1;
      push("sim_same_data", 32'h11);
      push("sim_same_mask", 32'h0080);
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;

      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99;
      lock_en = 1'b1; lock_addr = 4'd2;
      tick();
      $display("[tb] lock r2 + write r9 = 99");
      idle_inputs();
      rd_addr_a = 4'd2; rd_addr_b = 4'd9;
      #1;
      push("sim_diff_mask", 32'h0084);
      push("sim_diff_busy2", 32'h1);
      push("sim_diff_data9", 32'h99);
      push("sim_diff_busy9", 32'h0);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, rd_busy_a} !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_busy_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if (rd_data_b !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_b, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, rd_busy_b} !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_busy_b, e.val); else passed++;
   endtask

   task automatic test_bounds();
      // dut12 holds r5=deadbeef, r9=99, busy r2/r7 from the earlier traffic.
      wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hFFFF_FFFF;
      tick();
      $display("[tb] n12: write r13 (out of range)");
      idle_inputs();
      rd_addr_a = 4'd5; rd_addr_b = 4'd9;
      #1;
      push("bnd_wr_err", 32'h1);
      push("bnd_r5_kept", 32'hDEAD_BEEF);
      push("bnd_r9_kept", 32'h99);
      push("bnd_mask_kept", 32'h084);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, d12_wr_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_wr_err, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if (d12_rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if (d12_rd_data_b !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_rd_data_b, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({20'h0, d12_busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_busy_mask, e.val); else passed++;

      // Back-to-back bad writes keep the flag high, then it drops.
      for (int k = 0; k < 3; k++) begin
         wr_en = (k < 2); wr_addr = (k == 0) ? 4'd13 : 4'd14; wr_data = 32'h0BAD_0000;
         tick();
         push($sformatf("bnd_b2b_%0d", k), (k < 2) ? 32'h1 : 32'h0);
         e = exp_q.pop_front(); checks++;
         if ({31'h0, d12_wr_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_wr_err, e.val); else passed++;
      end
      idle_inputs();

      rd_addr_a = 4'd14;
      #1;
      $display("[tb] n12: read r14 (out of range)");
      push("bnd_rd14_data", 32'h0);
      push("bnd_rd14_busy", 32'h0);
      e = exp_q.pop_front(); checks++;
      if (d12_rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, d12_rd_busy_a} !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_rd_busy_a, e.val); else passed++;

      lock_en = 1'b1; lock_addr = 4'd12;
      tick();
      $display("[tb] n12: lock r12 (out of range)");
      idle_inputs();
      push("bnd_lock_err", 32'h1);
      push("bnd_lock_mask", 32'h084);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, d12_lock_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_lock_err, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({20'h0, d12_busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, d12_busy_mask, e.val); else passed++;
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h1;
      tick();
      $display("[tb] write r4 = 1");
      wr_data = 32'h2;
      rd_addr_a = 4'd4;
      #1;
      $display("[tb] present write r4 = 2 (bypass=%0d)", BYP);
      push("byp_pre_data", BYP ? 32'h2 : 32'h1);
      push("byp_pre_busy", 32'h0);
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, rd_busy_a} !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_busy_a, e.val); else passed++;
      tick();
      push("byp_post_data", 32'h2);
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;

      wr_data = 32'h3;
      lock_en = 1'b1; lock_addr = 4'd4;
      #1;
      $display("[tb] present write r4 = 3 + lock r4");
      push("byp_lock_data", BYP ? 32'h3 : 32'h2);
      push("byp_lock_busy", BYP ? 32'h1 : 32'h0);
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, rd_busy_a} !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_busy_a, e.val); else passed++;
      tick();
      idle_inputs();
      #1;
      push("byp_after_data", 32'h3);
      push("byp_after_busy", 32'h1);
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, rd_busy_a} !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_busy_a, e.val); else passed++;
   endtask

   task automatic test_reset_midop();
      lock_en = 1'b1; lock_addr = 4'd2;   // r2 is still busy
      tick();
      idle_inputs();
      $display("[tb] re-lock r2, then async reset mid-cycle");
      push("mid_lock_err_pre", 32'h1);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, lock_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, lock_err, e.val); else passed++;
      #2 rst = 1'b1;
      rd_addr_a = 4'd5; rd_addr_b = 4'd4;
      #1;
      push("mid_lock_err", 32'h0);
      push("mid_mask", 32'h0);
      push("mid_r5", 32'h0);
      push("mid_r4", 32'h0);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, lock_err} !== e.val) $display("FAIL %s: got %h expected %h", e.name, lock_err, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if (rd_data_b !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_b, e.val); else passed++;
      tick();
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hCAFE_F00D;
      lock_en = 1'b1; lock_addr = 4'd6;
      tick();
      $display("[tb] first edge after reset: write r1, lock r6");
      idle_inputs();
      rd_addr_a = 4'd1;
      #1;
      push("mid_first_data", 32'hCAFE_F00D);
      push("mid_first_mask", 32'h0040);
      e = exp_q.pop_front(); checks++;
      if (rd_data_a !== e.val) $display("FAIL %s: got %h expected %h", e.name, rd_data_a, e.val); else passed++;
      e = exp_q.pop_front(); checks++;
      if ({16'h0, busy_mask} !== e.val) $display("FAIL %s: got %h expected %h", e.name, busy_mask, e.val); else passed++;
   endtask

   initial begin
      test_reset();
      test_write_readback();
      test_scoreboard();
      test_simultaneous();
      test_bounds();
      test_bypass();
      test_reset_midop();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
